// File: rtl/vend_credit_fsm.sv
`default_nettype none
// ============================================================================
// Module      : vend_credit_fsm
// Description : Vending-machine front-end controller. Accepts coins, tracks
//               credit up to a ceiling, and on a select with enough credit
//               steps through VEND and (if a remainder exists) CHANGE.
//               Ports:
//                 clk, rst (sync, active-low)
//                 coin_valid, coin_val[1:0] : coin in (00=5,01=10,10=25,11=bad)
//                 select, cancel            : purchase / refund requests
//                 credit[CW-1:0]            : accumulated credit (registered)
//                 dispense, change_valid    : high while in VEND / CHANGE
//                 change_amt[CW-1:0]        : refund amount in CHANGE, else 0
//                 coin_reject               : pulse, cycle after a refused coin
//                 next_state                : pulse, first cycle of a new state
//                 state_bin[1:0]            : IDLE=0 COLLECT=1 VEND=2 CHANGE=3
// Revision    : 1.0 - initial release
// ============================================================================
module vend_credit_fsm #(
    parameter int PRICE      = 15,
    parameter int MAX_CREDIT = 35,
    parameter int CW         = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          coin_valid,
    input  logic [1:0]    coin_val,
    input  logic          select,
    input  logic          cancel,
    output logic [CW-1:0] credit,
    output logic          dispense,
    output logic          change_valid,
    output logic [CW-1:0] change_amt,
    output logic          coin_reject,
    output logic          next_state,
    output logic [1:0]    state_bin
);

    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_COLLECT = 2'd1;
    localparam logic [1:0]  c_VEND    = 2'd2;
    localparam logic [1:0]  c_CHANGE  = 2'd3;

    // Arithmetic is done one bit wider than the credit register so that the
    // ceiling compare can never be fooled by a wrapped sum.
    localparam logic [CW:0] c_PRICE   = (CW+1)'(PRICE);
    localparam logic [CW:0] c_MAX     = (CW+1)'(MAX_CREDIT);
    localparam logic [CW:0] c_COIN_5  = (CW+1)'(5);
    localparam logic [CW:0] c_COIN_10 = (CW+1)'(10);
    localparam logic [CW:0] c_COIN_25 = (CW+1)'(25);

    logic [1:0]    r_state;
    logic [CW-1:0] r_credit;
    logic          r_coin_reject;
    logic          r_next_state;

    logic [CW:0]   w_coin_amt;
    logic          w_coin_legal;
    logic [CW:0]   w_sum;
    logic [CW:0]   w_remain;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_credit_nxt;
    logic          w_reject_nxt;

    always_comb begin
        w_coin_legal = 1'b1;
        case (coin_val)
            2'b00:   w_coin_amt = c_COIN_5;
            2'b01:   w_coin_amt = c_COIN_10;
            2'b10:   w_coin_amt = c_COIN_25;
            default: begin
                w_coin_amt   = '0;
                w_coin_legal = 1'b0;
            end
        endcase
    end

    assign w_sum    = {1'b0, r_credit} + w_coin_amt;
    assign w_remain = {1'b0, r_credit} - c_PRICE;

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_reject_nxt = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (coin_valid) begin
                    if (w_coin_legal) begin
                        w_credit_nxt = w_coin_amt[CW-1:0];
                        w_state_nxt  = c_COLLECT;
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                end
            end
            c_COLLECT: begin
                // cancel beats select beats coin; a coin that loses to a
                // winning cancel/select is refused rather than silently eaten.
                if (cancel) begin
                    w_state_nxt  = c_CHANGE;
                    w_reject_nxt = coin_valid;
                end else if (select && ({1'b0, r_credit} >= c_PRICE)) begin
                    w_state_nxt  = c_VEND;
                    w_reject_nxt = coin_valid;
                end else if (coin_valid) begin
                    if (w_coin_legal && (w_sum <= c_MAX)) begin
                        w_credit_nxt = w_sum[CW-1:0];
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                end
            end
            c_VEND: begin
                w_credit_nxt = w_remain[CW-1:0];
                w_state_nxt  = (w_remain != '0) ? c_CHANGE : c_IDLE;
                w_reject_nxt = coin_valid;
            end
            default: begin
                w_credit_nxt = '0;
                w_state_nxt  = c_IDLE;
                w_reject_nxt = coin_valid;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= c_IDLE;
            r_credit      <= '0;
            r_coin_reject <= 1'b0;
            r_next_state  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_coin_reject <= w_reject_nxt;
            r_next_state  <= (w_state_nxt != r_state);
        end
    end

    // Status outputs are pure decodes of registered state, so they change
    // only at the clock edge.
    assign credit       = r_credit;
    assign state_bin    = r_state;
    assign dispense     = (r_state == c_VEND);
    assign change_valid = (r_state == c_CHANGE);
    assign change_amt   = (r_state == c_CHANGE) ? r_credit : '0;
    assign coin_reject  = r_coin_reject;
    assign next_state   = r_next_state;

endmodule
`default_nettype wire

// File: tb/tb_vend_credit_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_credit_fsm
// Description : Scoreboard bench for vend_credit_fsm. The stimulus process
//               pushes the hand-computed post-edge outputs for every cycle it
//               drives; a monitor pops and compares one entry per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_credit_fsm;

    localparam int CW = 6;

    typedef struct packed {
        logic [CW-1:0] credit;
        logic [1:0]    state;
        logic          disp;
        logic          chg_v;
        logic [CW-1:0] chg_amt;
        logic          rej;
        logic          ns;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          coin_valid;
    logic [1:0]    coin_val;
    logic          select;
    logic          cancel;
    logic [CW-1:0] credit;
    logic          dispense;
    logic          change_valid;
    logic [CW-1:0] change_amt;
    logic          coin_reject;
    logic          next_state;
    logic [1:0]    state_bin;

    exp_t q_exp[$];
    int   total = 0;
    int   bad   = 0;
    int   step_no = 0;

    vend_credit_fsm #(.PRICE(15), .MAX_CREDIT(35), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .coin_valid  (coin_valid),
        .coin_val    (coin_val),
        .select      (select),
        .cancel      (cancel),
        .credit      (credit),
        .dispense    (dispense),
        .change_valid(change_valid),
        .change_amt  (change_amt),
        .coin_reject (coin_reject),
        .next_state  (next_state),
        .state_bin   (state_bin)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per clock edge, checked 1 time unit after.
    always @(posedge clk) begin
        exp_t e;
        exp_t a;
        #1;
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            a = '{credit, state_bin, dispense, change_valid, change_amt,
                  coin_reject, next_state};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL cycle%0d: actual cr=%0d st=%0d disp=%0b cv=%0b camt=%0d rej=%0b ns=%0b required cr=%0d st=%0d disp=%0b cv=%0b camt=%0d rej=%0b ns=%0b",
                         total, a.credit, a.state, a.disp, a.chg_v, a.chg_amt, a.rej, a.ns,
                         e.credit, e.state, e.disp, e.chg_v, e.chg_amt, e.rej, e.ns);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic r, input logic cv, input logic [1:0] val,
                        input logic sel, input logic can,
                        input int e_cr, input int e_st, input logic e_d,
                        input logic e_cv, input int e_camt, input logic e_rej,
                        input logic e_ns);
        exp_t e;
        @(negedge clk);
        rst        = r;
        coin_valid = cv;
        coin_val   = val;
        select     = sel;
        cancel     = can;
        e.credit   = CW'(e_cr);
        e.state    = 2'(e_st);
        e.disp     = e_d;
        e.chg_v    = e_cv;
        e.chg_amt  = CW'(e_camt);
        e.rej      = e_rej;
        e.ns       = e_ns;
        q_exp.push_back(e);
        step_no++;
    endtask

    // Coin codes: 0=5c, 1=10c, 2=25c, 3=illegal.
    initial begin
        rst = 1'b0; coin_valid = 1'b0; coin_val = 2'd0; select = 1'b0; cancel = 1'b0;

        // Reset held with a coin present
        step(0,1,1,0,0,  0,0,0,0,0,0,0);
        step(0,1,1,0,0,  0,0,0,0,0,0,0);

        // Exact price: 10 + 5, select
        step(1,1,1,0,0, 10,1,0,0,0,0,1);
        step(1,1,0,0,0, 15,1,0,0,0,0,0);
        step(1,0,0,1,0, 15,2,1,0,0,0,1);
        step(1,0,0,0,0,  0,0,0,0,0,0,1);
        step(1,0,0,1,1,  0,0,0,0,0,0,0);   // select/cancel ignored in IDLE

        // Overpay with 25, coin dropped during VEND is refused
        step(1,1,2,0,0, 25,1,0,0,0,0,1);
        step(1,0,0,1,0, 25,2,1,0,0,0,1);
        step(1,1,0,0,0, 10,3,0,1,10,1,1);
        step(1,0,0,0,0,  0,0,0,0,0,0,1);
        step(1,0,0,0,0,  0,0,0,0,0,0,0);

        // Ceiling: 25 + 10 = 35, then 5 refused; cancel refunds 35
        step(1,1,2,0,0, 25,1,0,0,0,0,1);
        step(1,1,1,0,0, 35,1,0,0,0,0,0);
        step(1,1,0,0,0, 35,1,0,0,0,1,0);
        step(1,0,0,0,0, 35,1,0,0,0,0,0);
        step(1,0,0,0,1, 35,3,0,1,35,0,1);
        step(1,0,0,0,0,  0,0,0,0,0,0,1);

        // Illegal code in IDLE
        step(1,1,3,0,0,  0,0,0,0,0,1,0);
        step(1,0,0,0,0,  0,0,0,0,0,0,0);

        // Simultaneous cancel + select + coin with credit 10
        step(1,1,1,0,0, 10,1,0,0,0,0,1);
        step(1,1,0,1,1, 10,3,0,1,10,1,1);
        step(1,0,0,0,0,  0,0,0,0,0,0,1);

        // Short select still takes the coin; winning select refuses it
        step(1,1,0,0,0,  5,1,0,0,0,0,1);
        step(1,1,1,1,0, 15,1,0,0,0,0,0);
        step(1,1,3,0,0, 15,1,0,0,0,1,0);   // illegal code in COLLECT
        step(1,1,0,1,0, 15,2,1,0,0,1,1);
        step(1,0,0,0,0,  0,0,0,0,0,0,1);

        // Reset during VEND
        step(1,1,1,0,0, 10,1,0,0,0,0,1);
        step(1,1,2,0,0, 35,1,0,0,0,0,0);
        step(1,0,0,1,0, 35,2,1,0,0,0,1);
        step(0,0,0,0,0,  0,0,0,0,0,0,0);
        step(1,0,0,0,0,  0,0,0,0,0,0,0);
        step(1,0,0,0,0,  0,0,0,0,0,0,0);

        // Drain the scoreboard with a bounded wait.
        @(negedge clk);
        coin_valid = 1'b0; select = 1'b0; cancel = 1'b0;
        for (int i = 0; i < 20 && q_exp.size() > 0; i++) @(negedge clk);
        if (q_exp.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain: actual pending=%0d required pending=0", q_exp.size());
        end
        if (total != step_no) begin
            bad++;
            $display("FAIL count: actual checked=%0d required checked=%0d", total, step_no);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
